count_display_driver: RTL and testbench

Two-digit multiplexed 7-segment driver that consumes the 5-bit mod-20 count produced by the up/down counter and renders it as decimal 00–19 on a two-digit display. It sits between the counter's Q output and the board's segment/anode pins. It latches the count once per display frame so digits never tear. It converts the value to tens/ones, time-multiplexes the two digits with a programmable refresh divider, and flags out-of-range input.

---
 rtl/count_display_driver.sv | 101 ++++++++++
 tb/tb_count_display_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/count_display_driver.sv
// Two-digit multiplexed 7-segment driver for a mod-20 count (00-19).
// Latches the count once per frame, splits it into tens/ones and scans both digits.
module count_display_driver #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned COMMON_ANODE = 1,
  parameter int unsigned BLANK_LZ     = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] Q_IN,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       FRAME_TICK
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  localparam logic [6:0] SegDash  = 7'b0111111;
  localparam logic [6:0] SegBlank = 7'b1111111;

  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic            digit_sel_q, digit_sel_d;
  logic [4:0]      val_lat_q, val_lat_d;
  logic            frame_tick_q, frame_tick_d;
  logic            slot_end;

  // Active-low patterns, bit order g..a.
  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  always_comb begin
    slot_end     = (div_cnt_q == CntMax);
    div_cnt_d    = slot_end ? '0 : div_cnt_q + CntW'(1);
    digit_sel_d  = slot_end ? ~digit_sel_q : digit_sel_q;
    frame_tick_d = slot_end && digit_sel_q;
    val_lat_d    = (slot_end && digit_sel_q) ? Q_IN : val_lat_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt_q    <= '0;
      digit_sel_q  <= 1'b0;
      val_lat_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      digit_sel_q  <= digit_sel_d;
      val_lat_q    <= val_lat_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  logic       tens;
  logic [3:0] ones;
  logic       out_of_range;
  logic [6:0] seg_n;
  logic [1:0] an_n;

  always_comb begin
    tens         = (val_lat_q >= 5'd10);
    // Subtraction is modulo 16, so the low nibble alone yields the ones digit.
    ones         = val_lat_q[3:0] - (tens ? 4'd10 : 4'd0);
    out_of_range = (val_lat_q >= 5'd20);
    seg_n        = SegBlank;
    an_n         = 2'b11;
    if (!digit_sel_q) begin
      an_n  = 2'b10;
      seg_n = out_of_range ? SegDash : seg_of(ones);
    end else if (out_of_range) begin
      an_n  = 2'b01;
      seg_n = SegDash;
    end else if ((BLANK_LZ != 0) && !tens) begin
      an_n  = 2'b11;
      seg_n = SegBlank;
    end else begin
      an_n  = 2'b01;
      seg_n = seg_of({3'b000, tens});
    end
  end

  assign SEG        = (COMMON_ANODE != 0) ? seg_n : ~seg_n;
  assign AN         = (COMMON_ANODE != 0) ? an_n : ~an_n;
  assign FRAME_TICK = frame_tick_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver with CLK_DIV=4; three instances cover
// leading-zero blanking on/off and common-cathode polarity.
module tb_count_display_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] q;
  logic [6:0] seg, seg_nb, seg_ca0;
  logic [1:0] an, an_nb, an_ca0;
  logic       ft, ft_nb, ft_ca0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_display_driver #(.CLK_DIV(4), .COMMON_ANODE(1), .BLANK_LZ(1)) dut (
    .CLK(clk), .RST(rst), .Q_IN(q), .SEG(seg), .AN(an), .FRAME_TICK(ft)
  );

  count_display_driver #(.CLK_DIV(4), .COMMON_ANODE(1), .BLANK_LZ(0)) dut_nb (
    .CLK(clk), .RST(rst), .Q_IN(q), .SEG(seg_nb), .AN(an_nb), .FRAME_TICK(ft_nb)
  );

  count_display_driver #(.CLK_DIV(4), .COMMON_ANODE(0), .BLANK_LZ(1)) dut_ca0 (
    .CLK(clk), .RST(rst), .Q_IN(q), .SEG(seg_ca0), .AN(an_ca0), .FRAME_TICK(ft_ca0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    q   = 5'd13;
    tick();
    tick();
    checks++;
    if ({an, seg, ft} !== {2'b10, 7'b1000000, 1'b0}) begin
      errors++;
      $display("FAIL reset got an=%b seg=%b ft=%b exp an=10 seg=1000000 ft=0", an, seg, ft);
    end
    checks++;
    if ({an_ca0, seg_ca0, ft_ca0} !== {2'b01, 7'b0111111, 1'b0}) begin
      errors++;
      $display("FAIL reset_ca0 got an=%b seg=%b ft=%b exp an=01 seg=0111111 ft=0",
               an_ca0, seg_ca0, ft_ca0);
    end
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      tick();
      if (ft) n = i;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL first_tick got %0d cycles exp 8", n);
    end
    checks++;
    if ({an, seg} !== {2'b10, 7'b0110000}) begin
      errors++;
      $display("FAIL capture13 got an=%b seg=%b exp an=10 seg=0110000", an, seg);
    end
  endtask

  // Entered at frame cycle 0; leaves at frame cycle 0 of the frame showing 17.
  task automatic test_hold17();
    logic [1:0] ea;
    logic [6:0] es;
    q = 5'd17;
    repeat (8) tick();
    for (int i = 0; i < 16; i++) begin
      ea = ((i % 8) < 4) ? 2'b10 : 2'b01;
      es = ((i % 8) < 4) ? 7'b1111000 : 7'b1111001;
      checks++;
      if ({an, seg, ft} !== {ea, es, ((i % 8) == 0)}) begin
        errors++;
        $display("FAIL hold17 i=%0d got an=%b seg=%b ft=%b exp an=%b seg=%b ft=%b",
                 i, an, seg, ft, ea, es, ((i % 8) == 0));
      end
      tick();
    end
  endtask

  task automatic test_blank();
    q = 5'd5;
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i < 4) begin
        if ({an, seg, an_nb, seg_nb} !== {2'b10, 7'b0010010, 2'b10, 7'b0010010}) begin
          errors++;
          $display("FAIL blank_ones i=%0d got an=%b seg=%b an_nb=%b seg_nb=%b exp 10/0010010",
                   i, an, seg, an_nb, seg_nb);
        end
      end else begin
        if ({an, seg, an_nb, seg_nb} !== {2'b11, 7'b1111111, 2'b01, 7'b1000000}) begin
          errors++;
          $display("FAIL blank_tens i=%0d got an=%b seg=%b an_nb=%b seg_nb=%b exp 11/1111111 01/1000000",
                   i, an, seg, an_nb, seg_nb);
        end
        checks++;
        if ({an_ca0, seg_ca0} !== {2'b00, 7'b0000000}) begin
          errors++;
          $display("FAIL blank_ca0 i=%0d got an=%b seg=%b exp an=00 seg=0000000",
                   i, an_ca0, seg_ca0);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ea;
    logic [6:0] es;
    q = 5'd3;
    repeat (8) tick();
    tick();
    tick();
    q = 5'd12;
    for (int i = 2; i < 8; i++) begin
      ea = (i < 4) ? 2'b10 : 2'b11;
      es = (i < 4) ? 7'b0110000 : 7'b1111111;
      checks++;
      if ({an, seg, ft} !== {ea, es, 1'b0}) begin
        errors++;
        $display("FAIL hold3 i=%0d got an=%b seg=%b ft=%b exp an=%b seg=%b ft=0",
                 i, an, seg, ft, ea, es);
      end
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      ea = (i < 4) ? 2'b10 : 2'b01;
      es = (i < 4) ? 7'b0100100 : 7'b1111001;
      checks++;
      if ({an, seg, ft} !== {ea, es, (i == 0)}) begin
        errors++;
        $display("FAIL show12 i=%0d got an=%b seg=%b ft=%b exp an=%b seg=%b ft=%b",
                 i, an, seg, ft, ea, es, (i == 0));
      end
      tick();
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] ea;
    q = 5'd25;
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      ea = (i < 4) ? 2'b10 : 2'b01;
      checks++;
      if ({an, seg, an_nb, seg_nb} !== {ea, 7'b0111111, ea, 7'b0111111}) begin
        errors++;
        $display("FAIL dash i=%0d got an=%b seg=%b an_nb=%b seg_nb=%b exp an=%b seg=0111111",
                 i, an, seg, an_nb, seg_nb, ea);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    int n;
    q = 5'd12;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({an, seg, ft} !== {2'b10, 7'b1000000, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got an=%b seg=%b ft=%b exp an=10 seg=1000000 ft=0", an, seg, ft);
    end
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      tick();
      if (ft) n = i;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL mid_reset_tick got %0d cycles exp 8", n);
    end
    checks++;
    if ({an, seg} !== {2'b10, 7'b0100100}) begin
      errors++;
      $display("FAIL mid_reset_capture got an=%b seg=%b exp an=10 seg=0100100", an, seg);
    end
  endtask

  initial begin
    rst = 1'b1;
    q   = 5'd0;
    test_reset();
    test_hold17();
    test_blank();
    test_back_to_back();
    test_out_of_range();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
